// File: rtl/seq_addsub.sv
// seq_addsub: digit-serial adder/subtractor.
// Iterates a DIGIT-bit ripple-carry slice over a WIDTH-bit operand pair, one
// digit per clock, least significant digit first. A start/done handshake
// frames each operation; r/co/ovf only change when an operation completes.
//
// Optional feature macro: SEQ_ADDSUB_SUB_EN
//   defined   : sub=1 inverts b, giving a + ~b + ci (ci=1 for plain a-b)
//   undefined : sub is ignored and no inverter is built
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   request, accepted only while ready=1
//   sub    in   subtract select, sampled with start
//   a, b   in   operands, sampled with start
//   ci     in   carry into bit 0, sampled with start
//   ready  out  start can be accepted this cycle
//   busy   out  operation in progress
//   done   out  one-cycle pulse, r/co/ovf just updated
//   r      out  result (a + b' + ci) mod 2^WIDTH
//   co     out  carry out of bit WIDTH-1
//   ovf    out  two's-complement overflow
module seq_addsub #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] r,
  output logic             co,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] shadow;
  logic [WIDTH-1:0] shadow_next;
  logic [WIDTH-1:0] b_eff;
  logic [CW-1:0]    cnt;
  logic             carry;

  logic [DIGIT-1:0] s;
  logic [DIGIT:0]   c;

`ifdef SEQ_ADDSUB_SUB_EN
  assign b_eff = b ^ {WIDTH{sub}};
`else
  logic unused_sub;
  assign unused_sub = sub;
  assign b_eff      = b;
`endif

  // Ripple slice over the current (lowest) digit of the shift registers.
  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = carry;
    for (int i = 0; i < DIGIT; i++) begin
      s[i]   = a_sh[i] ^ b_sh[i] ^ c[i];
      c[i+1] = (a_sh[i] & b_sh[i]) | (a_sh[i] & c[i]) | (b_sh[i] & c[i]);
    end
  end

  // New digits enter the shadow from the top so that after N steps the
  // first digit has reached bit 0.
  assign shadow_next = (shadow >> DIGIT) | (WIDTH'(s) << (WIDTH - DIGIT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ready  <= 1'b1;
      busy   <= 1'b0;
      done   <= 1'b0;
      r      <= '0;
      co     <= 1'b0;
      ovf    <= 1'b0;
      a_sh   <= '0;
      b_sh   <= '0;
      shadow <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a;
            b_sh  <= b_eff;
            carry <= ci;
            cnt   <= '0;
            state <= RUN;
            ready <= 1'b0;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
            ready <= 1'b1;
            busy  <= 1'b0;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> DIGIT;
          b_sh   <= b_sh >> DIGIT;
          carry  <= c[DIGIT];
          shadow <= shadow_next;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            // Last digit: c[DIGIT-1] is the carry into the MSB.
            r     <= shadow_next;
            co    <= c[DIGIT];
            ovf   <= c[DIGIT] ^ c[DIGIT-1];
            state <= DONE;
            ready <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/seq_addsub.md
# seq_addsub

Multi-cycle, digit-serial adder/subtractor for the ALU datapath. It is the parametrised successor to the 1-bit full adder (`a`, `b`, `ci` → `r`, `co`). It chains `DIGIT` full-adder slices and iterates them over a `WIDTH`-bit operand pair, one digit per clock. It uses a start/done handshake and produces carry-out and signed-overflow flags. It sits between the operand registers and the ALU result mux, and trades latency for adder area.

## Interface
- `WIDTH`, default 16: operand/result width in bits. Must be a multiple of `DIGIT`.
- `DIGIT`, default 4: bits processed per cycle. `DIGIT == WIDTH` is legal and gives single-digit operation.
- Derived `N = WIDTH/DIGIT`: number of RUN cycles.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request. Accepted only on a cycle with `ready=1`.
- `sub`  in  1  subtract select, sampled with `start`. See Configuration.
- `a`  in  WIDTH  operand A, sampled with `start`.
- `b`  in  WIDTH  operand B, sampled with `start`.
- `ci`  in  1  carry-in into bit 0, sampled with `start`.
- `ready`  out  1  block can accept `start` this cycle.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle pulse; `r`/`co`/`ovf` are valid and updated.
- `r`  out  WIDTH  result.
- `co`  out  1  carry out of bit WIDTH-1.
- `ovf`  out  1  two's-complement overflow (carry into MSB XOR carry out of MSB).

## Operation
- FSM states:
  - IDLE: `ready=1`. On `start`, go to RUN.
  - RUN: `busy=1`, `ready=0`. Stays N cycles, then goes to DONE.
  - DONE: `done=1`, `ready=1`. Lasts one cycle. On `start`, go to RUN (back-to-back accepted); otherwise go to IDLE.
- On accept, the block latches:
  - A shift register with `a`.
  - A shift register with `b' = b ^ {WIDTH{sub_eff}}`.
  - The carry register with `ci`.
  - The digit counter, cleared to 0.
- RUN cycle k (k = 0..N-1):
  - Computes `{c, s} = A[k*DIGIT +: DIGIT] + B'[k*DIGIT +: DIGIT] + carry` with a DIGIT-slice ripple adder.
  - Stores `s` into the result shadow, stores `c` into the carry register, and increments the counter.
  - On the last digit, records carry-into-MSB for `ovf`.
- On the RUN→DONE transition, `r`, `co` and `ovf` are loaded together from the shadow and flags.
- `r`, `co` and `ovf` are stable at all other times. They hold the last completed result until the next completion; they never show partial digits.
- The result is `r = (a + b' + ci) mod 2^WIDTH`. `co` is bit WIDTH of the full sum.
- `start` while `ready=0` is ignored. No queuing; no error flag.
- Input changes after acceptance have no effect on the operation in flight.

## Timing
- Reset (async assert, `rst_n=0`) forces:
  - state = IDLE
  - `ready=1`, `busy=0`, `done=0`
  - `r=0`, `co=0`, `ovf=0`
  - counter and carry cleared.
- Release is synchronous to `clk`. The first `start` is accepted on the first rising edge with `rst_n=1`.
- Latency: `start` is sampled at edge E0. `busy=1` for the cycles after edges E0..E(N-1). `done=1` and the result is valid in the cycle after edge EN. For the defaults, `done` follows 5 edges after `start`.
- Throughput: one operation per N+1 cycles, with `start` held or pulsed in the DONE cycle.
- Reset mid-RUN aborts the operation. `done` does not fire, and outputs return to reset values.
- Counter wrap: the counter is `max(1,$clog2(N))` bits wide. On the last digit it is compared to N-1, so it never wraps through N.

## Configuration
- `SEQ_ADDSUB_SUB_EN` defined:
  - `sub_eff = sub`.
  - `sub=1` computes `a + ~b + ci`. The caller sets `ci=1` for a plain `a-b`, or `ci=0` for subtract-with-borrow chaining.
  - `co=1` means no borrow.
- `SEQ_ADDSUB_SUB_EN` undefined:
  - `sub_eff = 0`. The `sub` port is present but ignored, and no inverter logic is built.

## Test plan
All with `WIDTH=16`, `DIGIT=4`.
- Reset: `rst_n=0` → `ready=1`, `busy=0`, `done=0`, `r=0x0000`, `co=0`, `ovf=0`.
- `a=0x0001`, `b=0x0000`, `ci=0`, `start` → `busy` for 4 cycles, `done` pulse in cycle 5; `r=0x0001`, `co=0`, `ovf=0`.
- `a=0xFFFF`, `b=0x0001`, `ci=0` → `r=0x0000`, `co=1`, `ovf=0`. Then `a=0x7FFF`, `b=0x0001` issued back-to-back in the DONE cycle → `r=0x8000`, `co=0`, `ovf=1`.
- `a=0x0005`, `b=0x0007`, `sub=1`, `ci=1`:
  - With `SEQ_ADDSUB_SUB_EN` → `r=0xFFFE`, `co=0`, `ovf=0`.
  - Without it → `r=0x000D`, `co=0`.
- `start` pulsed during RUN with different operands → ignored; the first result is returned unchanged and only one `done` pulse occurs.
- `rst_n` dropped in RUN cycle 2 → immediate IDLE, no `done`, `r=0x0000`. The next `start` after release completes normally.
